// File: rtl/mem_tester.sv
// mem_tester: built-in memory self-test engine that drives the CPU-side port
// of the cache as an initiator. On start it writes pattern(i) over a word
// range, reads the range back and counts mismatches. The run always
// completes; results are held until the next accepted start.
// Optional feature macro: MEM_TESTER_INVERSE_PASS_EN adds a descending
// write/read pass of the inverted pattern after the ascending pass.
//
// Handshake with the cache: a transaction is issued by the edge that enters
// a transfer state or completes the previous transaction. Address, data and
// write enable are held until completion. The issue cycle itself is never
// sampled. After it, a write completes on the first edge that sees
// cache_busy low, and a read completes on the first edge that sees
// cache_data_out_ready high, with cache_data_out compared at that edge.
module mem_tester #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          WORD_COUNT   = 1024,
    parameter logic [31:0] SEED         = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic        pass,
    output logic [15:0] error_count,
    output logic [31:0] first_error_address,
    output logic [31:0] first_error_data,
    output logic        cache_enable,
    output logic [31:0] cache_address,
    output logic [31:0] cache_data_in,
    output logic [3:0]  cache_write_enable,
    input  logic [31:0] cache_data_out,
    input  logic        cache_data_out_ready,
    input  logic        cache_busy,
    output logic [2:0]  debug_state
);

    localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);
`ifdef MEM_TESTER_INVERSE_PASS_EN
    localparam logic [31:0] TOP_ADDRESS = BASE_ADDRESS + 32'(4 * (WORD_COUNT - 1));
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_UP = 3'd1,
        S_RD_UP = 3'd2,
`ifdef MEM_TESTER_INVERSE_PASS_EN
        S_WR_DN = 3'd3,
        S_RD_DN = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] idx;
    logic        armed;      // set once the issue cycle has passed
    logic        is_write;
    logic        is_read;
    logic        down;
    logic        last_word;
    logic        complete;
    logic        mismatch;
    logic [31:0] expected;

    function automatic logic [31:0] pattern(input logic [15:0] i);
        return {i, ~i} ^ SEED;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Per-state decode and transaction completion
    always_comb begin
        is_write = 1'b0;
        is_read  = 1'b0;
        down     = 1'b0;
        case (state)
            S_WR_UP: is_write = 1'b1;
            S_RD_UP: is_read  = 1'b1;
`ifdef MEM_TESTER_INVERSE_PASS_EN
            S_WR_DN: begin
                is_write = 1'b1;
                down     = 1'b1;
            end
            S_RD_DN: begin
                is_read = 1'b1;
                down    = 1'b1;
            end
`endif
            default: ;
        endcase
        last_word = down ? (idx == 16'd0) : (idx == LAST_IDX);
        expected  = down ? ~pattern(idx) : pattern(idx);
        complete  = armed && (is_write ? !cache_busy : (is_read && cache_data_out_ready));
        mismatch  = is_read && complete && (cache_data_out != expected);
    end

    // Next-state: a phase ends when its last word completes
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (start) next_state = S_WR_UP;
            S_WR_UP: if (complete && last_word) next_state = S_RD_UP;
`ifdef MEM_TESTER_INVERSE_PASS_EN
            S_RD_UP: if (complete && last_word) next_state = S_WR_DN;
            S_WR_DN: if (complete && last_word) next_state = S_RD_DN;
            S_RD_DN: if (complete && last_word) next_state = S_DONE;
`else
            S_RD_UP: if (complete && last_word) next_state = S_DONE;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        cache_enable       = is_write || is_read;
        cache_write_enable = is_write ? 4'b1111 : 4'b0000;
        pass               = done && (error_count == 16'd0);
        debug_state        = state;
    end

    // Datapath: word index, bus registers, error bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            idx                 <= 16'd0;
            armed               <= 1'b0;
            done                <= 1'b0;
            error_count         <= 16'd0;
            first_error_address <= 32'd0;
            first_error_data    <= 32'd0;
            cache_address       <= 32'd0;
            cache_data_in       <= 32'd0;
        end else if (state == S_IDLE || state == S_DONE) begin
            if (start) begin
                idx                 <= 16'd0;
                armed               <= 1'b0;
                done                <= 1'b0;
                error_count         <= 16'd0;
                first_error_address <= 32'd0;
                first_error_data    <= 32'd0;
                cache_address       <= BASE_ADDRESS;
                cache_data_in       <= pattern(16'd0);
            end
        end else if (!complete) begin
            armed <= 1'b1;
        end else begin
            armed <= 1'b0;
            if (mismatch) begin
                if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
                if (error_count == 16'd0) begin
                    first_error_address <= cache_address;
                    first_error_data    <= cache_data_out;
                end
            end
            case (state)
                S_WR_UP: begin
                    if (last_word) begin
                        idx           <= 16'd0;
                        cache_address <= BASE_ADDRESS;
                    end else begin
                        idx           <= idx + 16'd1;
                        cache_address <= cache_address + 32'd4;
                        cache_data_in <= pattern(idx + 16'd1);
                    end
                end
                S_RD_UP: begin
                    if (last_word) begin
`ifdef MEM_TESTER_INVERSE_PASS_EN
                        idx           <= LAST_IDX;
                        cache_address <= TOP_ADDRESS;
                        cache_data_in <= ~pattern(LAST_IDX);
`else
                        done          <= 1'b1;
`endif
                    end else begin
                        idx           <= idx + 16'd1;
                        cache_address <= cache_address + 32'd4;
                    end
                end
`ifdef MEM_TESTER_INVERSE_PASS_EN
                S_WR_DN: begin
                    if (last_word) begin
                        idx           <= LAST_IDX;
                        cache_address <= TOP_ADDRESS;
                    end else begin
                        idx           <= idx - 16'd1;
                        cache_address <= cache_address - 32'd4;
                        cache_data_in <= ~pattern(idx - 16'd1);
                    end
                end
                S_RD_DN: begin
                    if (last_word) begin
                        done <= 1'b1;
                    end else begin
                        idx           <= idx - 16'd1;
                        cache_address <= cache_address - 32'd4;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_tester.md
# mem_tester

Built-in memory self-test engine that drives the CPU-side port of `Cache` as an initiator, the requester end of the interface the cache serves. On `start` it sweeps a configurable word range: it writes a deterministic pattern, reads it back through the cache, and records mismatches. It sits between board-level control (buttons or UART) and the cache, in place of the CPU, for bring-up of the cache + PSRAM path.

## Interface
- `BASE_ADDRESS`, default 0: byte address of the first word; must be 4-aligned.
- `WORD_COUNT`, default 1024: number of 32-bit words tested; range 1..65536.
- `SEED`, default 32'h0000_0000: XOR mask applied to the pattern.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a test run; sampled only in IDLE or DONE.
- `done`  out  1  high from run completion until the next accepted `start`.
- `pass`  out  1  valid while `done` is high; 1 iff `error_count == 0`.
- `error_count`  out  16  mismatch count; saturates at 16'hFFFF.
- `first_error_address`  out  32  byte address of the first mismatch.
- `first_error_data`  out  32  data read at the first mismatch.
- `cache_enable`  out  1  enable to the cache.
- `cache_address`  out  32  byte address to the cache.
- `cache_data_in`  out  32  write data to the cache.
- `cache_write_enable`  out  4  byte write enables; 4'b1111 for writes, 0 for reads.
- `cache_data_out`  in  32  read data from the cache.
- `cache_data_out_ready`  in  1  read data valid.
- `cache_busy`  in  1  cache is stalled on a write or miss.

## Operation
- States: IDLE, WR_UP, RD_UP, WR_DN, RD_DN, DONE. WR_DN and RD_DN exist only with the macro enabled (see Configuration).
- Word index `i` and address `BASE_ADDRESS + 4*i`. `pattern(i) = {16'(i), ~16'(i)} ^ SEED`.
- IDLE/DONE, when `start` is high: clear `error_count`, `first_error_*`, `done`; set `i = 0`; go to WR_UP.
- WR_UP: write `pattern(i)` for i = 0..WORD_COUNT-1. After the last word, go to RD_UP with i = 0.
- RD_UP: read word i and compare it with `pattern(i)`. After the last word:
  - macro enabled: go to WR_DN with i = WORD_COUNT-1;
  - otherwise: go to DONE.
- WR_DN: write `~pattern(i)` for i descending to 0. Then go to RD_DN with i = WORD_COUNT-1.
- RD_DN: read and compare with `~pattern(i)`, descending. Then go to DONE.
- On a mismatch:
  - `error_count` increments unless it is saturated;
  - if this is the first mismatch of the run, latch `first_error_address` and `first_error_data`.
- The run always completes; there is no early abort on error.
- `cache_enable` is 1 in all transfer states and 0 in IDLE and DONE.
- In IDLE and DONE, `cache_write_enable = 0`, and `cache_address` and `cache_data_in` hold their last values.

## Timing
- A transaction is issued in cycle N: the address, data and write enable become valid after the edge that enters the state or completes the previous transaction. They are held stable until completion.
- Write completion: the first rising edge after cycle N that samples `cache_busy == 0`. The issue cycle itself is never sampled.
- Read completion: the first rising edge after cycle N that samples `cache_data_out_ready == 1`. `cache_data_out` is compared at that same edge.
- Transactions are back-to-back: the completion edge loads the next address and data, so a hit costs 2 cycles per word.
- There is no timeout. A cache that never completes hangs the engine until `rst`.
- `start` in IDLE or DONE moves to WR_UP at the next edge. `start` in any other state is ignored.
- DONE: `done = 1` at the edge that completes the final read. `pass` is valid from the same cycle.
- `WORD_COUNT = 1`: each phase is a single transaction; the up and down sweeps touch the same word.
- Reset values, at any time including mid-run:
  - state IDLE;
  - `done`, `pass`, `error_count`, `first_error_address`, `first_error_data` all 0;
  - `cache_enable`, `cache_write_enable`, `cache_address`, `cache_data_in` all 0.
- A transaction cut off by `rst` is abandoned; no completion is waited for.

## Configuration
- `MEM_TESTER_INVERSE_PASS_EN` defined: four phases, in order WR_UP, RD_UP, WR_DN, RD_DN. This catches stuck bits, and the descending sweep catches address aliasing.
- Not defined: two phases, WR_UP then RD_UP. WR_DN and RD_DN are not synthesised.

## Test plan
- Fault-free run, macro off:
  - stimulus: bench cache model with hits in 1 cycle; `WORD_COUNT = 4`, `SEED = 0`; pulse `start`.
  - response: writes 32'h0000FFFF, 32'h0001FFFE, 32'h0002FFFD, 32'h0003FFFC at addresses 0, 4, 8, C; then 4 reads; `done = 1`, `pass = 1`, `error_count = 0`; 16 cycles from `start` to `done`.
- Stalled cache:
  - stimulus: model holds `cache_busy` for 6 cycles on each write and delays `data_out_ready` by 6 cycles on each read.
  - response: address and data stay stable throughout each stall; `pass = 1`.
- Single stuck bit:
  - stimulus: model forces bit 0 of word 2 to 0; macro on; `WORD_COUNT = 4`.
  - response: `error_count = 1` (the upward check reads 32'h0002FFFC instead of FFFD); `first_error_address = 8`; `first_error_data = 32'h0002FFFC`; `pass = 0`. The downward check expects 32'hFFFD0002, which has bit 0 clear and so matches.
- Saturation:
  - stimulus: model always returns 0; `WORD_COUNT = 65536`, `SEED = 32'hFFFF0000`.
  - response: `error_count = 16'hFFFF`; `first_error_address = BASE_ADDRESS`.
- Reset mid-run:
  - stimulus: assert `rst` for 1 cycle during RD_UP.
  - response: all outputs 0 and state IDLE on the next cycle; a new `start` then runs to completion with `pass = 1`.
- Start while busy:
  - stimulus: pulse `start` during WR_UP.
  - response: no restart; `i` continues incrementing; a single `done`.
